// File: rtl/cpu_run_ctrl.sv
// -----------------------------------------------------------------------------
// cpu_run_ctrl
//
// Run controller for the pipelined RISC-V core. It sequences the core's
// active-low reset and clock enable, counts executed RUN cycles, and halts on
// a cycle limit, a PC breakpoint or (optionally) an ebreak fetch. It also
// keeps the last TRACE_DEPTH fetched {PC, instruction} pairs in a ring buffer
// that can be read back at any time.
//
// Build option:
//   CPU_RUN_CTRL_EBREAK_EN  - when defined, an ebreak fetch (32'h0010_0073)
//                             halts the run with cause 2'b11. When undefined,
//                             instr_in is only stored in the trace.
//
// Ports:
//   CLK            in   clock, rising edge
//   Reset          in   asynchronous active-high reset
//   start          in   one-cycle pulse, begins/restarts a run (IDLE/HALT)
//   pc_in          in   core fetch PC
//   instr_in       in   core fetched instruction
//   bp_addr        in   breakpoint addresses, entry k at [k*PC_W +: PC_W]
//   bp_valid       in   per-breakpoint enable
//   trace_rd_idx   in   trace read index, 0 = most recent
//   cpu_resetn     out  core reset, active low
//   cpu_en         out  core clock enable
//   done           out  high while halted
//   halt_cause     out  00 none, 01 limit, 10 breakpoint, 11 ebreak
//   cycle_cnt      out  RUN cycles executed in the current run
//   trace_count    out  valid trace entries, saturating at TRACE_DEPTH
//   trace_rd_pc    out  registered trace PC (0 for an invalid index)
//   trace_rd_instr out  registered trace instruction (0 for an invalid index)
// -----------------------------------------------------------------------------
module cpu_run_ctrl #(
    parameter int PC_W        = 32,
    parameter int RST_CYCLES  = 1,
    parameter int MAX_CYCLES  = 23,
    parameter int TRACE_DEPTH = 8,
    parameter int NUM_BP      = 2
) (
    input  logic                           CLK,
    input  logic                           Reset,
    input  logic                           start,
    input  logic [PC_W-1:0]                pc_in,
    input  logic [31:0]                    instr_in,
    input  logic [NUM_BP*PC_W-1:0]         bp_addr,
    input  logic [NUM_BP-1:0]              bp_valid,
    input  logic [$clog2(TRACE_DEPTH)-1:0] trace_rd_idx,
    output logic                           cpu_resetn,
    output logic                           cpu_en,
    output logic                           done,
    output logic [1:0]                     halt_cause,
    output logic [31:0]                    cycle_cnt,
    output logic [$clog2(TRACE_DEPTH):0]   trace_count,
    output logic [PC_W-1:0]                trace_rd_pc,
    output logic [31:0]                    trace_rd_instr
);

    localparam int IW  = $clog2(TRACE_DEPTH);
    localparam int RCW = $clog2(RST_CYCLES + 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RST  = 2'd1,
        ST_RUN  = 2'd2,
        ST_HALT = 2'd3
    } state_t;

    state_t            state;
    state_t            next_state;
    logic [RCW-1:0]    rst_cnt;
    logic [IW-1:0]     wr_ptr;
    logic [PC_W-1:0]   ring_pc    [TRACE_DEPTH];
    logic [31:0]       ring_instr [TRACE_DEPTH];

    logic              bp_hit;
    logic              ebreak_hit;
    logic              limit_hit;
    logic [31:0]       cycle_inc;
    logic [1:0]        run_cause;
    logic              enter_rst;
    logic [IW-1:0]     rd_slot;
    logic              rd_valid;

    // Breakpoint match: any enabled entry equal to the sampled fetch PC.
    always_comb begin
        bp_hit = 1'b0;
        for (int k = 0; k < NUM_BP; k++) begin
            bp_hit = bp_hit | (bp_valid[k] & (pc_in == bp_addr[k*PC_W +: PC_W]));
        end
    end

`ifdef CPU_RUN_CTRL_EBREAK_EN
    assign ebreak_hit = (instr_in == 32'h0010_0073);
`else
    assign ebreak_hit = 1'b0;
`endif

    // The limit compares the count after this cycle is added, so the run
    // lasts exactly MAX_CYCLES RUN cycles.
    assign cycle_inc = cycle_cnt + 32'd1;
    assign limit_hit = (cycle_inc == 32'(MAX_CYCLES));

    // Halt cause priority: breakpoint > ebreak > limit.
    always_comb begin
        if (bp_hit) begin
            run_cause = 2'b10;
        end else if (ebreak_hit) begin
            run_cause = 2'b11;
        end else if (limit_hit) begin
            run_cause = 2'b01;
        end else begin
            run_cause = 2'b00;
        end
    end

    // FSM state register.
    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // FSM next-state logic; start is ignored in RST and RUN.
    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE: begin
                if (start) next_state = ST_RST;
                else       next_state = ST_IDLE;
            end
            ST_RST: begin
                if (rst_cnt == RCW'(1)) next_state = ST_RUN;
                else                    next_state = ST_RST;
            end
            ST_RUN: begin
                if (run_cause != 2'b00) next_state = ST_HALT;
                else                    next_state = ST_RUN;
            end
            ST_HALT: begin
                if (start) next_state = ST_RST;
                else       next_state = ST_HALT;
            end
            default: next_state = ST_IDLE;
        endcase
    end

    assign enter_rst = (next_state == ST_RST) && (state != ST_RST);

    // Run bookkeeping: reset countdown, cycle counter, cause, trace pointers.
    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            rst_cnt     <= '0;
            cycle_cnt   <= 32'd0;
            halt_cause  <= 2'b00;
            trace_count <= '0;
            wr_ptr      <= '0;
        end else if (enter_rst) begin
            rst_cnt     <= RCW'(RST_CYCLES);
            cycle_cnt   <= 32'd0;
            halt_cause  <= 2'b00;
            trace_count <= '0;
            wr_ptr      <= '0;
        end else if (state == ST_RST) begin
            rst_cnt <= rst_cnt - RCW'(1);
        end else if (state == ST_RUN) begin
            cycle_cnt  <= cycle_inc;
            halt_cause <= run_cause;
            wr_ptr     <= wr_ptr + IW'(1);
            if (trace_count != (IW+1)'(TRACE_DEPTH)) begin
                trace_count <= trace_count + (IW+1)'(1);
            end
        end
    end

    // Trace ring storage: one entry written per RUN cycle.
    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            for (int i = 0; i < TRACE_DEPTH; i++) begin
                ring_pc[i]    <= '0;
                ring_instr[i] <= 32'd0;
            end
        end else if ((state == ST_RUN) && !enter_rst) begin
            ring_pc[wr_ptr]    <= pc_in;
            ring_instr[wr_ptr] <= instr_in;
        end
    end

    // Index 0 is the newest entry, i.e. the slot just behind the write pointer.
    assign rd_slot  = wr_ptr - IW'(1) - trace_rd_idx;
    assign rd_valid = ({1'b0, trace_rd_idx} < trace_count);

    // Registered trace read; uses pre-write ring contents in a write cycle.
    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            trace_rd_pc    <= '0;
            trace_rd_instr <= 32'd0;
        end else if (rd_valid) begin
            trace_rd_pc    <= ring_pc[rd_slot];
            trace_rd_instr <= ring_instr[rd_slot];
        end else begin
            trace_rd_pc    <= '0;
            trace_rd_instr <= 32'd0;
        end
    end

    // Core control outputs registered from the state being entered.
    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            cpu_resetn <= 1'b0;
            cpu_en     <= 1'b0;
            done       <= 1'b0;
        end else begin
            cpu_resetn <= (next_state == ST_RUN) || (next_state == ST_HALT);
            cpu_en     <= (next_state == ST_RUN);
            done       <= (next_state == ST_HALT);
        end
    end

endmodule

// File: tb/tb_cpu_run_ctrl.sv
module tb_cpu_run_ctrl;

    localparam int MAXC = 23;
    localparam int TD   = 8;
    localparam int RSTC = 1;
`ifdef CPU_RUN_CTRL_EBREAK_EN
    localparam bit EBK_EN = 1'b1;
`else
    localparam bit EBK_EN = 1'b0;
`endif

    logic        CLK = 1'b0;
    logic        Reset;
    logic        start;
    logic [31:0] pc_in;
    logic [31:0] instr_in;
    logic [63:0] bp_addr;
    logic [1:0]  bp_valid;
    logic [2:0]  trace_rd_idx;
    logic        cpu_resetn;
    logic        cpu_en;
    logic        done;
    logic [1:0]  halt_cause;
    logic [31:0] cycle_cnt;
    logic [3:0]  trace_count;
    logic [31:0] trace_rd_pc;
    logic [31:0] trace_rd_instr;

    logic [31:0] ebreak_op;
    logic [31:0] stim_pc    [64];
    logic [31:0] stim_instr [64];
    int tests;
    int fails;

    cpu_run_ctrl dut (
        .CLK(CLK), .Reset(Reset), .start(start), .pc_in(pc_in), .instr_in(instr_in),
        .bp_addr(bp_addr), .bp_valid(bp_valid), .trace_rd_idx(trace_rd_idx),
        .cpu_resetn(cpu_resetn), .cpu_en(cpu_en), .done(done), .halt_cause(halt_cause),
        .cycle_cnt(cycle_cnt), .trace_count(trace_count), .trace_rd_pc(trace_rd_pc),
        .trace_rd_instr(trace_rd_instr)
    );

    always #5 CLK = ~CLK;

    // Reference model: scan the planned fetch stream for the first halting cycle.
    task automatic model_run(output int n, output logic [1:0] cause);
        n = MAXC;
        cause = 2'b01;
        for (int i = 0; i < MAXC; i++) begin
            bit bp;
            bp = (bp_valid[0] && stim_pc[i] == bp_addr[31:0]) ||
                 (bp_valid[1] && stim_pc[i] == bp_addr[63:32]);
            if (bp) begin n = i + 1; cause = 2'b10; break; end
            if (EBK_EN && stim_instr[i] == ebreak_op) begin n = i + 1; cause = 2'b11; break; end
        end
    endtask

    function automatic logic [31:0] rand_instr();
        logic [31:0] v;
        v = $urandom;
        if (v == 32'h0010_0073) v = v ^ 32'h0000_0001;
        return v;
    endfunction

    task automatic fill_linear();
        for (int i = 0; i < 64; i++) begin
            stim_pc[i]    = 32'(4 * i);
            stim_instr[i] = rand_instr();
        end
    endtask

    // Start a run from IDLE/HALT and check the whole run against the model.
    task automatic run_check(input string name);
        int n, rst_low, en_cnt, budget, kept;
        logic [1:0] cause;
        logic [31:0] exp_pc, exp_in;
        model_run(n, cause);
        @(posedge CLK); #1; start = 1'b1;
        @(posedge CLK); #1; start = 1'b0;
        tests++;
        if (done !== 1'b0 || cycle_cnt !== 32'd0 || trace_count !== 4'd0 || cpu_resetn !== 1'b0 || cpu_en !== 1'b0) begin
            fails++;
            $display("FAIL %s start_clear: done=%b cnt=%0d tc=%0d rstn=%b en=%b, want 0 0 0 0 0",
                     name, done, cycle_cnt, trace_count, cpu_resetn, cpu_en);
        end
        rst_low = 0; budget = 0;
        while (cpu_en !== 1'b1 && budget < 16) begin
            if (cpu_resetn === 1'b0) rst_low++;
            @(posedge CLK); #1; budget++;
        end
        tests++;
        if (rst_low != RSTC || cpu_en !== 1'b1 || cpu_resetn !== 1'b1) begin
            fails++;
            $display("FAIL %s reset_len: low=%0d en=%b rstn=%b, want %0d 1 1", name, rst_low, cpu_en, cpu_resetn, RSTC);
        end
        en_cnt = 0;
        while (cpu_en === 1'b1 && en_cnt < 64) begin
            tests++;
            if (cycle_cnt !== 32'(en_cnt)) begin
                fails++;
                $display("FAIL %s live_cnt: got %0d want %0d", name, cycle_cnt, en_cnt);
            end
            pc_in = stim_pc[en_cnt];
            instr_in = stim_instr[en_cnt];
            @(posedge CLK); #1;
            en_cnt++;
        end
        kept = (n < TD) ? n : TD;
        tests++;
        if (en_cnt != n || done !== 1'b1 || cpu_resetn !== 1'b1 || cpu_en !== 1'b0) begin
            fails++;
            $display("FAIL %s run_len: en_cycles=%0d done=%b rstn=%b en=%b, want %0d 1 1 0",
                     name, en_cnt, done, cpu_resetn, cpu_en, n);
        end
        tests++;
        if (cycle_cnt !== 32'(n) || halt_cause !== cause || trace_count !== 4'(kept)) begin
            fails++;
            $display("FAIL %s halt_state: cnt=%0d cause=%b tc=%0d, want %0d %b %0d",
                     name, cycle_cnt, halt_cause, trace_count, n, cause, kept);
        end
        for (int idx = 0; idx < TD; idx++) begin
            trace_rd_idx = 3'(idx);
            @(posedge CLK); #1;
            exp_pc = (idx < kept) ? stim_pc[n-1-idx] : 32'd0;
            exp_in = (idx < kept) ? stim_instr[n-1-idx] : 32'd0;
            tests++;
            if (trace_rd_pc !== exp_pc || trace_rd_instr !== exp_in) begin
                fails++;
                $display("FAIL %s trace_idx%0d: pc=%h instr=%h, want %h %h", name, idx, trace_rd_pc, trace_rd_instr, exp_pc, exp_in);
            end
        end
        tests++;
        if (done !== 1'b1 || cycle_cnt !== 32'(n)) begin
            fails++;
            $display("FAIL %s halt_hold: done=%b cnt=%0d, want 1 %0d", name, done, cycle_cnt, n);
        end
    endtask

    task automatic test_reset();
        int budget;
        Reset = 1'b1;
        repeat (2) @(posedge CLK);
        #1;
        tests++;
        if ({cpu_resetn, cpu_en, done, halt_cause, cycle_cnt, trace_count, trace_rd_pc, trace_rd_instr} !== '0) begin
            fails++;
            $display("FAIL reset_values: rstn=%b en=%b done=%b cause=%b cnt=%0d tc=%0d pc=%h in=%h, want all 0",
                     cpu_resetn, cpu_en, done, halt_cause, cycle_cnt, trace_count, trace_rd_pc, trace_rd_instr);
        end
        Reset = 1'b0;
        repeat (3) @(posedge CLK);
        #1;
        tests++;
        if ({cpu_resetn, cpu_en, done, halt_cause, cycle_cnt, trace_count, trace_rd_pc, trace_rd_instr} !== '0) begin
            fails++;
            $display("FAIL idle_no_start: rstn=%b en=%b done=%b cnt=%0d tc=%0d, want all 0",
                     cpu_resetn, cpu_en, done, cycle_cnt, trace_count);
        end
        // Reset in the middle of a run.
        fill_linear();
        start = 1'b1; @(posedge CLK); #1; start = 1'b0;
        budget = 0;
        while (cpu_en !== 1'b1 && budget < 16) begin @(posedge CLK); #1; budget++; end
        for (int i = 0; i < 5; i++) begin
            pc_in = stim_pc[i]; instr_in = stim_instr[i];
            @(posedge CLK); #1;
        end
        tests++;
        if (cpu_en !== 1'b1 || cycle_cnt !== 32'd5) begin
            fails++;
            $display("FAIL pre_reset_run: en=%b cnt=%0d, want 1 5", cpu_en, cycle_cnt);
        end
        Reset = 1'b1; #1;
        tests++;
        if (cpu_resetn !== 1'b0 || cpu_en !== 1'b0 || cycle_cnt !== 32'd0 || done !== 1'b0 || trace_count !== 4'd0) begin
            fails++;
            $display("FAIL mid_run_reset: rstn=%b en=%b cnt=%0d done=%b tc=%0d, want 0 0 0 0 0",
                     cpu_resetn, cpu_en, cycle_cnt, done, trace_count);
        end
        @(posedge CLK); #1; Reset = 1'b0;
        repeat (2) @(posedge CLK);
        #1;
        tests++;
        if (cpu_resetn !== 1'b0 || cpu_en !== 1'b0 || cycle_cnt !== 32'd0 || trace_rd_pc !== 32'd0) begin
            fails++;
            $display("FAIL post_reset_idle: rstn=%b en=%b cnt=%0d pc=%h, want 0 0 0 0", cpu_resetn, cpu_en, cycle_cnt, trace_rd_pc);
        end
    endtask

    task automatic test_cycle_limit();
        bp_valid = 2'b00;
        bp_addr = {$urandom, $urandom};
        for (int i = 0; i < 64; i++) begin
            stim_pc[i] = $urandom;
            stim_instr[i] = rand_instr();
        end
        run_check("cycle_limit");
    endtask

    task automatic test_breakpoint();
        fill_linear();
        bp_valid = 2'b10;
        bp_addr = {32'h0000_0010, 32'h0000_0008};
        run_check("breakpoint");
    endtask

    task automatic test_priority();
        fill_linear();
        bp_valid = 2'b01;
        bp_addr = {32'h0000_0000, 32'h0000_0018};
        stim_instr[6] = ebreak_op;
        run_check("prio_bp_over_ebreak");
        fill_linear();
        bp_valid = 2'b00;
        stim_instr[3] = ebreak_op;
        run_check("ebreak_alone");
    endtask

    task automatic test_trace_wrap();
        fill_linear();
        bp_valid = 2'b01;
        bp_addr = {32'h0000_0000, 32'h0000_0004};
        run_check("trace_two_entries");
        bp_addr = {32'h0000_0000, 32'h0000_0028};
        run_check("trace_wrap");
    endtask

    task automatic test_random();
        for (int r = 0; r < 6; r++) begin
            bp_valid = 2'($urandom_range(0, 3));
            bp_addr = {32'(4 * $urandom_range(0, 31)), 32'(4 * $urandom_range(0, 31))};
            for (int i = 0; i < 64; i++) begin
                stim_pc[i] = 32'(4 * $urandom_range(0, 47));
                stim_instr[i] = ($urandom_range(0, 9) == 0) ? ebreak_op : rand_instr();
            end
            run_check("random");
        end
    endtask

    initial begin
        tests = 0; fails = 0;
        ebreak_op = 32'h0010_0073;
        start = 1'b0; pc_in = 32'd0; instr_in = 32'd0;
        bp_addr = 64'd0; bp_valid = 2'b00; trace_rd_idx = 3'd0;
        test_reset();
        test_cycle_limit();
        test_breakpoint();
        test_priority();
        test_trace_wrap();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
